// File: rtl/dp_controller_if.sv
// Instruction handshake bundle between an instruction source and dp_controller.
// Handshake: a transfer happens on a rising clk edge where instr_valid and
// instr_ready are both high; the source holds instr stable until then.
interface dp_controller_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/dp_controller.sv
// dp_controller: multi-cycle control FSM for the ARM32 data-processing datapath.
// FETCH -> DECODE -> LOAD -> EXEC -> WB; DECODE returns to FETCH on an illegal
// instruction or a failed condition.
// Optional feature macro COND_EXEC_EN: when defined, the condition field is
// evaluated against NZCV in status_in; otherwise every legal instruction runs as AL.
// Handshake: instruction accepted on a rising edge with instr_valid && instr_ready;
// instr_ready is high only in FETCH, so instr_valid while busy is ignored.
module dp_controller #(
    parameter int FLAG_MSB = 31
) (
    input  logic                clk,
    input  logic                rst_n,
    dp_controller_if.slave      ifc,
    input  logic [31:0]         status_in,
    output logic [3:0]          w_addr,
    output logic [3:0]          A_addr,
    output logic [3:0]          B_addr,
    output logic [3:0]          shift_addr,
    output logic                w_en,
    output logic                en_A,
    output logic                en_B,
    output logic                en_C,
    output logic                en_status,
    output logic                wb_sel,
    output logic                sel_A,
    output logic                sel_B,
    output logic                sel_shift,
    output logic [1:0]          shift_op,
    output logic [31:0]         shift_imme,
    output logic [31:0]         imme_data,
    output logic [2:0]          ALU_op,
    output logic                busy,
    output logic                illegal,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_LOAD   = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_ir;
    logic        w_op_ok;
    logic        w_is_cmp;
    logic        w_legal;
    logic        w_cond_pass;
    logic [63:0] w_imm_dbl;
    logic        w_unused_status;

    // Only the NZCV nibble of status_in matters to this block.
    assign w_unused_status = ^status_in;

    // State register and instruction register; IR loads only on an accepted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && ifc.instr_valid) begin
                r_ir <= ifc.instr;
            end
        end
    end

    // Opcode decode: ALU operation and whether the opcode is supported.
    always_comb begin
        w_op_ok = 1'b0;
        ALU_op  = 3'b000;
        case (r_ir[24:21])
            4'b0000: begin w_op_ok = 1'b1;     ALU_op = 3'b010; end
            4'b0001: begin w_op_ok = 1'b1;     ALU_op = 3'b100; end
            4'b0010: begin w_op_ok = 1'b1;     ALU_op = 3'b001; end
            4'b0100: begin w_op_ok = 1'b1;     ALU_op = 3'b000; end
            4'b1100: begin w_op_ok = 1'b1;     ALU_op = 3'b011; end
            4'b1010: begin w_op_ok = r_ir[20]; ALU_op = 3'b001; end
            4'b1101: begin w_op_ok = 1'b1;     ALU_op = 3'b000; end
            default: begin w_op_ok = 1'b0;     ALU_op = 3'b000; end
        endcase
    end

    assign w_is_cmp = (r_ir[24:21] == 4'b1010);
    // A register-specified shift needs bit 7 clear; NV is never executable.
    assign w_legal  = (r_ir[27:26] == 2'b00) && (r_ir[15:12] != 4'hF) && w_op_ok
                   && !(!r_ir[25] && r_ir[4] && r_ir[7]) && (r_ir[31:28] != 4'hF);

`ifdef COND_EXEC_EN
    // Standard ARM condition evaluation against N,Z,C,V.
    always_comb begin
        logic w_n, w_z, w_c, w_v;
        w_n = status_in[FLAG_MSB];
        w_z = status_in[FLAG_MSB-1];
        w_c = status_in[FLAG_MSB-2];
        w_v = status_in[FLAG_MSB-3];
        w_cond_pass = 1'b1;
        case (r_ir[31:28])
            4'h0: w_cond_pass = w_z;
            4'h1: w_cond_pass = !w_z;
            4'h2: w_cond_pass = w_c;
            4'h3: w_cond_pass = !w_c;
            4'h4: w_cond_pass = w_n;
            4'h5: w_cond_pass = !w_n;
            4'h6: w_cond_pass = w_v;
            4'h7: w_cond_pass = !w_v;
            4'h8: w_cond_pass = w_c && !w_z;
            4'h9: w_cond_pass = !w_c || w_z;
            4'hA: w_cond_pass = (w_n == w_v);
            4'hB: w_cond_pass = (w_n != w_v);
            4'hC: w_cond_pass = !w_z && (w_n == w_v);
            4'hD: w_cond_pass = w_z || (w_n != w_v);
            default: w_cond_pass = 1'b1;
        endcase
    end
`else
    assign w_cond_pass = 1'b1;
`endif

    // Operand/address fields are pure functions of IR, stable from DECODE to WB.
    always_comb begin
        w_imm_dbl  = {24'b0, r_ir[7:0], 24'b0, r_ir[7:0]} >> {r_ir[11:8], 1'b0};
        imme_data  = w_imm_dbl[31:0];
        shift_imme = {27'b0, r_ir[11:7]};
        shift_op   = r_ir[6:5];
        sel_shift  = r_ir[4];
        sel_B      = r_ir[25];
        sel_A      = (r_ir[24:21] == 4'b1101);
        shift_addr = r_ir[11:8];
        A_addr     = r_ir[19:16];
        B_addr     = r_ir[3:0];
        w_addr     = r_ir[15:12];
        wb_sel     = 1'b0;
    end

    // Next-state and per-state enables; each enable is high only in its own state.
    always_comb begin
        w_next          = r_state;
        ifc.instr_ready = 1'b0;
        en_A            = 1'b0;
        en_B            = 1'b0;
        en_C            = 1'b0;
        en_status       = 1'b0;
        w_en            = 1'b0;
        illegal         = 1'b0;
        case (r_state)
            S_FETCH: begin
                ifc.instr_ready = 1'b1;
                if (ifc.instr_valid) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (!w_legal) begin
                    illegal = 1'b1;
                    w_next  = S_FETCH;
                end else if (!w_cond_pass) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                en_A   = 1'b1;
                en_B   = 1'b1;
                w_next = S_EXEC;
            end
            S_EXEC: begin
                en_C      = 1'b1;
                en_status = r_ir[20] | w_is_cmp;
                w_next    = S_WB;
            end
            S_WB: begin
                w_en   = !w_is_cmp;
                w_next = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign busy      = (r_state != S_FETCH);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_dp_controller.sv
// Bench for dp_controller: directed cases with literal expectations plus a
// randomized instruction stream checked every cycle against a timeline model.
module tb_dp_controller;

    logic        clk;
    logic        rst_n;
    logic [31:0] status_in;
    logic [3:0]  w_addr, A_addr, B_addr, shift_addr;
    logic        w_en, en_A, en_B, en_C, en_status, wb_sel, sel_A, sel_B, sel_shift;
    logic [1:0]  shift_op;
    logic [31:0] shift_imme, imme_data;
    logic [2:0]  ALU_op;
    logic        busy, illegal;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    dp_controller_if ifc();

    dp_controller #(.FLAG_MSB(31)) dut (
        .clk(clk), .rst_n(rst_n), .ifc(ifc), .status_in(status_in),
        .w_addr(w_addr), .A_addr(A_addr), .B_addr(B_addr), .shift_addr(shift_addr),
        .w_en(w_en), .en_A(en_A), .en_B(en_B), .en_C(en_C), .en_status(en_status),
        .wb_sel(wb_sel), .sel_A(sel_A), .sel_B(sel_B), .sel_shift(sel_shift),
        .shift_op(shift_op), .shift_imme(shift_imme), .imme_data(imme_data),
        .ALU_op(ALU_op), .busy(busy), .illegal(illegal), .dbg_state(dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model (spec-level) ----------------
    function automatic bit m_legal(input logic [31:0] w);
        bit op_ok;
        case (w[24:21])
            4'd0, 4'd1, 4'd2, 4'd4, 4'd12, 4'd13: op_ok = 1;
            4'd10:   op_ok = w[20];
            default: op_ok = 0;
        endcase
        return (w[27:26] == 2'b00) && (w[15:12] != 4'd15) && op_ok
            && !(w[25] == 1'b0 && w[4] && w[7]) && (w[31:28] != 4'hF);
    endfunction

    function automatic bit m_cond(input logic [3:0] c, input logic [31:0] st);
`ifdef COND_EXEC_EN
        bit n, z, cf, v;
        n = st[31]; z = st[30]; cf = st[29]; v = st[28];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1;
        endcase
`else
        return (c == c) || (st == st);
`endif
    endfunction

    function automatic logic [2:0] m_aluop(input logic [3:0] op);
        case (op)
            4'd0:    return 3'b010;
            4'd1:    return 3'b100;
            4'd2:    return 3'b001;
            4'd10:   return 3'b001;
            4'd12:   return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] w);
        logic [63:0] d;
        int r;
        r = 2 * int'(w[11:8]);
        d = {32'd0, 24'd0, w[7:0]};
        d = (d >> r) | (d << (32 - r));
        return d[31:0];
    endfunction

    // m_phase = cycles since the accept edge (0 = waiting for an instruction)
    int          m_phase = 0;
    logic [31:0] m_ir    = 0;
    logic [3:0]  exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            exp_q.delete();
        end else if (m_phase == 0) begin
            if (ifc.instr_valid) begin
                m_phase = 1;
                m_ir    = ifc.instr;
            end
        end else if (m_phase == 1) begin
            m_phase = (m_legal(m_ir) && m_cond(m_ir[31:28], status_in)) ? 2 : 0;
        end else if (m_phase == 4) begin
            m_phase = 0;
        end else begin
            m_phase = m_phase + 1;
        end
    end

    // Compare process: every negedge
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_enables", {en_A, en_B, en_C, en_status, w_en, illegal}, 0);
        end else begin
            bit is_cmp;
            is_cmp = (m_ir[24:21] == 4'd10);
            chk("instr_ready", ifc.instr_ready, m_phase == 0);
            chk("busy", busy, m_phase != 0);
            chk("illegal", illegal, m_phase == 1 && !m_legal(m_ir));
            chk("en_A", en_A, m_phase == 2);
            chk("en_B", en_B, m_phase == 2);
            chk("en_C", en_C, m_phase == 3);
            chk("en_status", en_status, m_phase == 3 && (m_ir[20] || is_cmp));
            chk("w_en", w_en, m_phase == 4 && !is_cmp);
            if (m_phase >= 1) begin
                chk("A_addr", A_addr, m_ir[19:16]);
                chk("B_addr", B_addr, m_ir[3:0]);
                chk("w_addr", w_addr, m_ir[15:12]);
                chk("sel_B", sel_B, m_ir[25]);
                chk("wb_sel", wb_sel, 0);
                chk("shift_imme", shift_imme, m_ir[11:7]);
                chk("imme_data", imme_data, m_imm(m_ir));
                if (m_legal(m_ir)) begin
                    chk("ALU_op", ALU_op, m_aluop(m_ir[24:21]));
                    chk("sel_A", sel_A, m_ir[24:21] == 4'd13);
                end
                if (!m_ir[25]) begin
                    chk("shift_op", shift_op, m_ir[6:5]);
                    chk("sel_shift", sel_shift, m_ir[4]);
                    if (m_ir[4]) chk("shift_addr", shift_addr, m_ir[11:8]);
                end
            end
            // scoreboard: destination register expected at writeback
            if (m_phase == 1 && m_legal(m_ir) && m_cond(m_ir[31:28], status_in) && !is_cmp)
                exp_q.push_back(m_ir[15:12]);
            if (w_en) begin
                if (exp_q.size() == 0) chk("wb_unexpected", 1, 0);
                else chk("wb_dest", w_addr, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    // Instruction presented at once (held even while busy); status switched
    // only in the FETCH cycle so the previous instruction's DECODE is undisturbed.
    task automatic send(input logic [31:0] ins, input logic [31:0] st);
        bit took;
        took = 0;
        ifc.instr       = ins;
        ifc.instr_valid = 1'b1;
        for (int g = 0; g < 20 && !took; g++) begin
            @(negedge clk);
            if (ifc.instr_ready) begin
                took      = 1;
                status_in = st;
            end
            @(posedge clk);
        end
        #1 ifc.instr_valid = 1'b0;
        if (!took) chk("send_timeout", 0, 1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [3:0]  ops [7];
        ops = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd12, 4'd13, 4'd10};
        w = $urandom();
        if ($urandom_range(0, 9) < 8) w[27:26] = 2'b00;
        if ($urandom_range(0, 9) < 8) w[24:21] = ops[$urandom_range(0, 6)];
        if (w[31:28] == 4'hF && $urandom_range(0, 3) != 0) w[31:28] = 4'hE;
        if (w[15:12] == 4'hF && $urandom_range(0, 3) != 0) w[15:12] = 4'($urandom_range(0, 14));
        if ($urandom_range(0, 1) == 1) w[7] = 1'b0;
        return w;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n           = 1'b0;
        ifc.instr_valid = 1'b0;
        ifc.instr       = '0;
        status_in       = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy_lit", busy, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", ifc.instr_ready, 1);

        // 1: ADD r2,r1,#5
        send(32'hE2812005, 32'h0);
        @(negedge clk); chk("t1_busy", busy, 1);
        @(negedge clk); chk("t1_enA", en_A, 1); chk("t1_Aaddr", A_addr, 4'd1);
        @(negedge clk); chk("t1_enC", en_C, 1); chk("t1_imm", imme_data, 32'd5);
        chk("t1_aluop", ALU_op, 3'b000); chk("t1_selB", sel_B, 1);
        @(negedge clk); chk("t1_wen", w_en, 1); chk("t1_waddr", w_addr, 4'd2);
        @(negedge clk); chk("t1_ready", ifc.instr_ready, 1);

        // 2: MOV r0,#0xFF000000
        send(32'hE3A004FF, 32'h0);
        @(negedge clk); chk("t2_imm", imme_data, 32'hFF000000);
        chk("t2_selA", sel_A, 1); chk("t2_waddr", w_addr, 4'd0);

        // 3: CMP r1,r2,LSL r3
        send(32'hE1510312, 32'h0);
        @(negedge clk); chk("t3_saddr", shift_addr, 4'd3);
        chk("t3_selsh", sel_shift, 1); chk("t3_shop", shift_op, 2'b00);
        @(negedge clk);
        @(negedge clk); chk("t3_enstat", en_status, 1);
        @(negedge clk); chk("t3_wen", w_en, 0);

        // 4: ADDEQ with Z=0
        send(32'h02812005, 32'h0);
        @(negedge clk);
        @(negedge clk);
`ifdef COND_EXEC_EN
        chk("t4_enA", en_A, 0); chk("t4_busy", busy, 0);
`else
        chk("t4_enA", en_A, 1);
        @(negedge clk);
        @(negedge clk); chk("t4_wen", w_en, 1);
`endif

        // 5: LDR -> illegal
        send(32'hE5912000, 32'h0);
        @(negedge clk); chk("t5_illegal", illegal, 1);
        @(negedge clk); chk("t5_illegal_off", illegal, 0);
        chk("t5_ready", ifc.instr_ready, 1);

        // 6: reset during EXEC
        send(32'hE2812005, 32'h0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("t6_enC", en_C, 0); chk("t6_busy", busy, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); chk("t6_ready", ifc.instr_ready, 1); chk("t6_busy2", busy, 0);
        send(32'hE2812005, 32'h0);
        repeat (4) @(negedge clk);
        chk("t6_wen", w_en, 1); chk("t6_waddr", w_addr, 4'd2);

        // randomized stream
        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(rand_instr(), $urandom());
        end
        repeat (8) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
